// File: rtl/pixel_stream_master_if.sv
// rtl/pixel_stream_master_if.sv - pixel in/out streams and iomem bus bundle for pixel_stream_master
interface pixel_stream_master_if;
    logic [7:0]  s_pixel;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_pixel;
    logic        m_valid;
    logic        m_ready;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Block side: consumes the input stream, produces the output stream, initiates bus accesses
    modport master (
        input  s_pixel, s_valid,
        output s_ready,
        output m_pixel, m_valid,
        input  m_ready,
        output mem_valid, mem_wstrb, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    // Environment side: pixel source, pixel sink and bus responder
    modport slave (
        output s_pixel, s_valid,
        input  s_ready,
        input  m_pixel, m_valid,
        output m_ready,
        input  mem_valid, mem_wstrb, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/pixel_stream_master.sv
// rtl/pixel_stream_master.sv - iomem bus master streaming pixels through the accelerator register window
// Optional feature macro: PSM_STATUS_POLL_EN (poll STAT bit0 before every pixel-in write)
module pixel_stream_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          POLL_LIMIT = 255
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [15:0]                   len,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err,
    pixel_stream_master_if.master         ifc
);

    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'h0000_0000;
    localparam logic [31:0] MODE_ADDR = BASE_ADDR + 32'h0000_0004;
    localparam logic [31:0] PIN_ADDR  = BASE_ADDR + 32'h0000_0010;
    localparam logic [31:0] POUT_ADDR = BASE_ADDR + 32'h0000_0014;
    // Index of the last status read allowed in one wait
    localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

    typedef enum logic [3:0] {
        IDLE,
        CFG_MODE,
        GET_PIX,
        POLL_RDY,
        WR_PIX,
        POLL_VAL,
        RD_PIX,
        EMIT,
        FINISH
    } state_t;

    state_t      state;
    logic [1:0]  mode_q;
    logic [15:0] len_q;
    logic [15:0] cnt;
    logic [15:0] poll_cnt;
    logic [7:0]  pix_q;

    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        bus_state;
    logic        ack;

    // Bus access descriptor for the current state; only consumed when a request is launched
    always_comb begin
        req_addr  = STAT_ADDR;
        req_wstrb = 4'h0;
        req_wdata = 32'h0;
        bus_state = 1'b0;
        case (state)
            CFG_MODE: begin
                req_addr  = MODE_ADDR;
                req_wstrb = 4'hF;
                req_wdata = {30'b0, mode_q};
                bus_state = 1'b1;
            end
            POLL_RDY: bus_state = 1'b1;
            WR_PIX: begin
                req_addr  = PIN_ADDR;
                req_wstrb = 4'hF;
                req_wdata = {24'b0, pix_q};
                bus_state = 1'b1;
            end
            POLL_VAL: bus_state = 1'b1;
            RD_PIX: begin
                req_addr  = POUT_ADDR;
                bus_state = 1'b1;
            end
            default: bus_state = 1'b0;
        endcase
        ack = ifc.mem_valid && ifc.mem_ready;
    end

    // Job FSM with registered outputs; bus request launched only while mem_valid is low,
    // so the cycle after every handshake always has mem_valid low
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            mode_q        <= 2'b00;
            len_q         <= 16'h0;
            cnt           <= 16'h0;
            poll_cnt      <= 16'h0;
            pix_q         <= 8'h0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            ifc.s_ready   <= 1'b0;
            ifc.m_valid   <= 1'b0;
            ifc.m_pixel   <= 8'h0;
            ifc.mem_valid <= 1'b0;
            ifc.mem_wstrb <= 4'h0;
            ifc.mem_addr  <= 32'h0;
            ifc.mem_wdata <= 32'h0;
        end else begin
            done <= 1'b0;

            if (bus_state) begin
                if (!ifc.mem_valid) begin
                    ifc.mem_valid <= 1'b1;
                    ifc.mem_addr  <= req_addr;
                    ifc.mem_wstrb <= req_wstrb;
                    ifc.mem_wdata <= req_wdata;
                end else if (ifc.mem_ready) begin
                    ifc.mem_valid <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        len_q       <= len;
                        cnt         <= 16'h0;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        state       <= CFG_MODE;
                    end
                end

                CFG_MODE: begin
                    if (ack) begin
                        if (len_q == 16'h0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state       <= GET_PIX;
                            ifc.s_ready <= 1'b1;
                        end
                    end
                end

                GET_PIX: begin
                    if (ifc.s_valid && ifc.s_ready) begin
                        pix_q       <= ifc.s_pixel;
                        ifc.s_ready <= 1'b0;
                        poll_cnt    <= 16'h0;
`ifdef PSM_STATUS_POLL_EN
                        state       <= POLL_RDY;
`else
                        state       <= WR_PIX;
`endif
                    end
                end

`ifdef PSM_STATUS_POLL_EN
                POLL_RDY: begin
                    if (ack) begin
                        if (ifc.mem_rdata[0]) begin
                            state <= WR_PIX;
                        end else if (poll_cnt == POLL_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= FINISH;
                            done        <= 1'b1;
                        end else begin
                            poll_cnt <= poll_cnt + 16'd1;
                        end
                    end
                end
`endif

                WR_PIX: begin
                    if (ack) begin
                        poll_cnt <= 16'h0;
                        state    <= POLL_VAL;
                    end
                end

                POLL_VAL: begin
                    if (ack) begin
                        if (ifc.mem_rdata[1]) begin
                            state <= RD_PIX;
                        end else if (poll_cnt == POLL_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= FINISH;
                            done        <= 1'b1;
                        end else begin
                            poll_cnt <= poll_cnt + 16'd1;
                        end
                    end
                end

                RD_PIX: begin
                    if (ack) begin
                        ifc.m_pixel <= ifc.mem_rdata[7:0];
                        ifc.m_valid <= 1'b1;
                        state       <= EMIT;
                    end
                end

                EMIT: begin
                    if (ifc.m_ready) begin
                        ifc.m_valid <= 1'b0;
                        cnt         <= cnt + 16'd1;
                        // Compare before increment so len = 16'hFFFF never wraps
                        if (cnt == len_q - 16'd1) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state       <= GET_PIX;
                            ifc.s_ready <= 1'b1;
                        end
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_master.sv
// tb/tb_pixel_stream_master.sv - directed self-checking bench for pixel_stream_master
module tb_pixel_stream_master;

    localparam logic [31:0] A_STAT = 32'h0300_0000;
    localparam logic [31:0] A_MODE = 32'h0300_0004;
    localparam logic [31:0] A_PIN  = 32'h0300_0010;
    localparam logic [31:0] A_POUT = 32'h0300_0014;
`ifdef PSM_STATUS_POLL_EN
    localparam int RDY_READS = 1;
`else
    localparam int RDY_READS = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] len = 16'h0;
    logic        busy;
    logic        done;
    logic        timeout_err;

    pixel_stream_master_if bus_if();

    pixel_stream_master #(
        .BASE_ADDR (32'h0300_0000),
        .POLL_LIMIT(4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .mode       (mode),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err),
        .ifc        (bus_if.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pixel source: a flat table with a monotonic consume pointer
    logic [7:0] in_pix [0:63];
    int in_n = 0;
    int consumed = 0;
    assign bus_if.s_valid = (consumed < in_n);
    assign bus_if.s_pixel = in_pix[consumed[5:0]];

    always @(posedge clk) begin
        if (bus_if.s_valid && bus_if.s_ready) consumed <= consumed + 1;
    end

    task automatic load(input logic [7:0] p);
        in_pix[in_n[5:0]] = p;
        in_n++;
    endtask

    // Accelerator responder: STAT bit0 always set, bit1 set after val_delay reads following a PIN write
    int         val_delay   = 0;
    bit         never_valid = 1'b0;
    bit         ack_rand    = 1'b0;
    int         wait_cnt    = 0;
    int         cur_delay   = 0;
    logic [1:0] acc_mode    = 2'b00;
    logic [7:0] pout        = 8'h0;
    bit         pin_pending = 1'b0;
    int         polls       = 0;

    always @(posedge clk) begin
        if (!resetn) begin
            bus_if.mem_ready <= 1'b0;
            wait_cnt         <= 0;
            pin_pending      <= 1'b0;
            polls            <= 0;
        end else if (bus_if.mem_ready) begin
            bus_if.mem_ready <= 1'b0;
        end else if (bus_if.mem_valid) begin
            if (wait_cnt < cur_delay) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                wait_cnt         <= 0;
                cur_delay        <= ack_rand ? int'($urandom_range(0, 7)) : 0;
                bus_if.mem_ready <= 1'b1;
                bus_if.mem_rdata <= 32'h0;
                if (bus_if.mem_wstrb == 4'hF) begin
                    if (bus_if.mem_addr == A_MODE) acc_mode <= bus_if.mem_wdata[1:0];
                    if (bus_if.mem_addr == A_PIN) begin
                        pout        <= (acc_mode == 2'b01) ? ~bus_if.mem_wdata[7:0] : bus_if.mem_wdata[7:0];
                        pin_pending <= 1'b1;
                        polls       <= 0;
                    end
                end else begin
                    if (bus_if.mem_addr == A_STAT) begin
                        bus_if.mem_rdata <= {30'b0, (pin_pending && !never_valid && polls >= val_delay), 1'b1};
                        polls <= polls + 1;
                    end
                    if (bus_if.mem_addr == A_POUT) begin
                        bus_if.mem_rdata <= {24'b0, pout};
                        pin_pending      <= 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: bus log, output log, pulse/cycle counters and bus protocol rules
    logic [31:0] log_addr  [0:1023];
    logic [31:0] log_wdata [0:1023];
    logic [3:0]  log_wstrb [0:1023];
    logic [7:0]  out_pix   [0:255];
    int bus_n = 0, out_n = 0, done_n = 0, srdy_cyc = 0, mval_cyc = 0;
    int stat_after_pin = 0, stat_before_pin = 0, proto_err = 0;
    bit pin_seen = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0, mon_hs = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;
    logic [3:0]  prev_wstrb = 4'h0;

    always @(negedge clk) begin
        #1;
        if (!resetn) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            pin_seen   = 1'b0;
        end else begin
            mon_hs = bus_if.mem_valid && bus_if.mem_ready;
            if (prev_hs && bus_if.mem_valid) proto_err++;
            if (prev_valid && !prev_hs && bus_if.mem_valid &&
                (bus_if.mem_addr !== prev_addr || bus_if.mem_wdata !== prev_wdata ||
                 bus_if.mem_wstrb !== prev_wstrb)) proto_err++;
            if (mon_hs) begin
                log_addr[bus_n[9:0]]  = bus_if.mem_addr;
                log_wdata[bus_n[9:0]] = bus_if.mem_wdata;
                log_wstrb[bus_n[9:0]] = bus_if.mem_wstrb;
                bus_n++;
                if (bus_if.mem_wstrb == 4'hF && bus_if.mem_addr == A_PIN) begin
                    pin_seen       = 1'b1;
                    stat_after_pin = 0;
                end
                if ((bus_if.mem_wstrb == 4'hF && bus_if.mem_addr == A_MODE) ||
                    (bus_if.mem_wstrb == 4'h0 && bus_if.mem_addr == A_POUT)) pin_seen = 1'b0;
                if (bus_if.mem_wstrb == 4'h0 && bus_if.mem_addr == A_STAT) begin
                    stat_after_pin++;
                    if (!pin_seen) stat_before_pin++;
                end
            end
            if (bus_if.m_valid && bus_if.m_ready) begin
                out_pix[out_n[7:0]] = bus_if.m_pixel;
                out_n++;
            end
            if (done) done_n++;
            if (bus_if.s_ready) srdy_cyc++;
            if (bus_if.m_valid) mval_cyc++;
            prev_valid = bus_if.mem_valid;
            prev_hs    = mon_hs;
            prev_addr  = bus_if.mem_addr;
            prev_wdata = bus_if.mem_wdata;
            prev_wstrb = bus_if.mem_wstrb;
        end
    end

    task automatic start_job(input logic [1:0] m, input logic [15:0] l);
        @(negedge clk);
        mode  = m;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 2000) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            k++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_done_low"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, o0, d0, sb0, sr0, mv0, k, stab;
        bus_if.m_ready = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy",      32'(busy),             32'd0);
        check("rst_done",      32'(done),             32'd0);
        check("rst_terr",      32'(timeout_err),      32'd0);
        check("rst_s_ready",   32'(bus_if.s_ready),   32'd0);
        check("rst_m_valid",   32'(bus_if.m_valid),   32'd0);
        check("rst_m_pixel",   32'(bus_if.m_pixel),   32'd0);
        check("rst_mem_valid", 32'(bus_if.mem_valid), 32'd0);
        check("rst_mem_wstrb", 32'(bus_if.mem_wstrb), 32'd0);
        check("rst_mem_addr",  bus_if.mem_addr,       32'd0);
        check("rst_mem_wdata", bus_if.mem_wdata,      32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // T1 bypass, immediate responder
        load(8'd10); load(8'd20); load(8'd30);
        b0 = bus_n; o0 = out_n; d0 = done_n; sb0 = stat_before_pin;
        start_job(2'b00, 16'd3);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1");
        check("t1_mode_addr",  log_addr[b0[9:0]],        A_MODE);
        check("t1_mode_wdata", log_wdata[b0[9:0]],       32'h0);
        check("t1_mode_wstrb", 32'(log_wstrb[b0[9:0]]),  32'hF);
        check("t1_out_count",  32'(out_n - o0),          32'd3);
        check("t1_pix0",       32'(out_pix[o0[7:0]]),       32'd10);
        check("t1_pix1",       32'(out_pix[8'(o0 + 1)]),    32'd20);
        check("t1_pix2",       32'(out_pix[8'(o0 + 2)]),    32'd30);
        check("t1_done_pulses", 32'(done_n - d0),        32'd1);
        check("t1_terr",       32'(timeout_err),         32'd0);
        check("t1_rdy_reads",  32'(stat_before_pin - sb0), 32'(3 * RDY_READS));

        // T2 invert with output backpressure
        val_delay = 2;
        bus_if.m_ready = 1'b0;
        load(8'h00); load(8'hF0);
        o0 = out_n;
        start_job(2'b01, 16'd2);
        k = 0;
        while (!bus_if.m_valid && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t2_m_valid", 32'(bus_if.m_valid), 32'd1);
        check("t2_stall_pix", 32'(bus_if.m_pixel), 32'hFF);
        stab = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_if.m_pixel !== 8'hFF || bus_if.m_valid !== 1'b1 || bus_if.s_ready !== 1'b0) stab++;
        end
        check("t2_stable", 32'(stab), 32'd0);
        bus_if.m_ready = 1'b1;
        wait_done("t2");
        check("t2_out_count", 32'(out_n - o0),            32'd2);
        check("t2_pix0",      32'(out_pix[o0[7:0]]),      32'hFF);
        check("t2_pix1",      32'(out_pix[8'(o0 + 1)]),   32'h0F);

        // T3 poll timeout on pixel_valid
        never_valid = 1'b1;
        load(8'h05);
        o0 = out_n; d0 = done_n;
        start_job(2'b00, 16'd1);
        wait_done("t3");
        check("t3_stat_reads", 32'(stat_after_pin), 32'd4);
        check("t3_terr",       32'(timeout_err),    32'd1);
        check("t3_done_pulses", 32'(done_n - d0),   32'd1);
        check("t3_no_output",  32'(out_n - o0),     32'd0);
        never_valid = 1'b0;

        // T4 zero-length job; its start also clears the sticky timeout
        b0 = bus_n; d0 = done_n; sr0 = srdy_cyc; mv0 = mval_cyc;
        start_job(2'b10, 16'd0);
        check("t4_terr_cleared", 32'(timeout_err), 32'd0);
        wait_done("t4");
        check("t4_bus_ops",    32'(bus_n - b0),        32'd1);
        check("t4_mode_addr",  log_addr[b0[9:0]],      A_MODE);
        check("t4_mode_wdata", log_wdata[b0[9:0]],     32'h2);
        check("t4_s_ready",    32'(srdy_cyc - sr0),    32'd0);
        check("t4_m_valid",    32'(mval_cyc - mv0),    32'd0);
        check("t4_done_pulses", 32'(done_n - d0),      32'd1);

        // T5 random ack latency, then reset in the middle of a PIN write
        ack_rand = 1'b1;
        val_delay = 1;
        load(8'h01); load(8'h02); load(8'h03); load(8'h04);
        o0 = out_n;
        start_job(2'b01, 16'd4);
        wait_done("t5");
        check("t5_out_count", 32'(out_n - o0),          32'd4);
        check("t5_pix0",      32'(out_pix[o0[7:0]]),    32'hFE);
        check("t5_pix1",      32'(out_pix[8'(o0 + 1)]), 32'hFD);
        check("t5_pix2",      32'(out_pix[8'(o0 + 2)]), 32'hFC);
        check("t5_pix3",      32'(out_pix[8'(o0 + 3)]), 32'hFB);
        load(8'h33);
        start_job(2'b00, 16'd1);
        k = 0;
        while (!(bus_if.mem_valid && bus_if.mem_addr == A_PIN && bus_if.mem_wstrb == 4'hF) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t5_in_wr_pix", 32'(bus_if.mem_addr == A_PIN && bus_if.mem_valid), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("t5_rst_mem_valid", 32'(bus_if.mem_valid), 32'd0);
        check("t5_rst_busy",      32'(busy),             32'd0);
        check("t5_rst_s_ready",   32'(bus_if.s_ready),   32'd0);
        check("t5_rst_m_valid",   32'(bus_if.m_valid),   32'd0);
        @(negedge clk);
        resetn = 1'b1;
        ack_rand = 1'b0;
        val_delay = 0;
        @(negedge clk);

        // T6 two pixels after reset; STAT reads before PIN only with the ready poll built in
        load(8'h07); load(8'h09);
        o0 = out_n; sb0 = stat_before_pin;
        start_job(2'b00, 16'd2);
        wait_done("t6");
        check("t6_out_count", 32'(out_n - o0),              32'd2);
        check("t6_pix0",      32'(out_pix[o0[7:0]]),        32'h07);
        check("t6_pix1",      32'(out_pix[8'(o0 + 1)]),     32'h09);
        check("t6_rdy_reads", 32'(stat_before_pin - sb0),   32'(2 * RDY_READS));
        check("t6_terr",      32'(timeout_err),             32'd0);

        check("bus_protocol", 32'(proto_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
